// File: rtl/y_int_pkg.sv
// Shared definitions for the y_int_ctrl interrupt controller:
// FSM state encoding, register map and interrupt line count.
package y_int_pkg;

   localparam int NIRQ = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } state_e;

   localparam logic [1:0] ADDR_MASK = 2'd0;
   localparam logic [1:0] ADDR_BASE = 2'd1;
   localparam logic [1:0] ADDR_EPC  = 2'd2;
   localparam logic [1:0] ADDR_EOI  = 2'd3;

endpackage

// File: rtl/y_prio_enc4.sv
// Fixed-priority encoder: lowest set index of eligible_i wins.
module y_prio_enc4
   import y_int_pkg::*;
(
   input  logic [NIRQ-1:0] eligible_i,
   output logic            valid_o,
   output logic [1:0]      id_o
);

   // Select the lowest-numbered eligible request
   always_comb begin
      valid_o = 1'b1;
      id_o    = 2'd0;
      if (eligible_i[0]) begin
         id_o = 2'd0;
      end else if (eligible_i[1]) begin
         id_o = 2'd1;
      end else if (eligible_i[2]) begin
         id_o = 2'd2;
      end else if (eligible_i[3]) begin
         id_o = 2'd3;
      end else begin
         valid_o = 1'b0;
         id_o    = 2'd0;
      end
   end

endmodule

// File: rtl/y_int_ctrl.sv
// Four-line, non-nesting interrupt controller: edge-detected requests,
// programmable mask and vector base, one-cycle INT pulse per accepted request.
module y_int_ctrl
   import y_int_pkg::*;
#(
   parameter int unsigned VEC_SHIFT = 4,
   parameter logic [31:0] RST_BASE  = 32'h0000_0080
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NIRQ-1:0] irq,
   input  logic [31:0]     pcNext,
   input  logic            regWe,
   input  logic [1:0]      regAddr,
   input  logic [31:0]     regWd,
   output logic [31:0]     regRd,
   output logic            INT,
   output logic [31:0]     entryPoint,
   output logic            busy
);

   state_e          state_q;
   logic [NIRQ-1:0] irq_q;
   logic [NIRQ-1:0] pending_q;
   logic [NIRQ-1:0] pending_d;
   logic [NIRQ-1:0] mask_q;
   logic [31:0]     base_q;
   logic [31:0]     epc_q;
   logic [31:0]     entry_q;
   logic [1:0]      id_q;
   logic            int_q;
   logic            busy_q;

   logic [NIRQ-1:0] rise_s;
   logic [NIRQ-1:0] eligible_s;
   logic [NIRQ-1:0] clr_s;
   logic            enc_valid_s;
   logic [1:0]      enc_id_s;
   logic            take_s;
   logic            eoi_s;
   logic [31:0]     vec_off_s;

   assign rise_s     = irq & ~irq_q;
   assign eligible_s = pending_q & mask_q;
   assign take_s     = (state_q == IDLE) && enc_valid_s;
   assign eoi_s      = regWe && (regAddr == ADDR_EOI) && (state_q == SERVICE);
   assign vec_off_s  = 32'(enc_id_s) << VEC_SHIFT;

   y_prio_enc4 u_prio (
      .eligible_i (eligible_s),
      .valid_o    (enc_valid_s),
      .id_o       (enc_id_s)
   );

   // Clear the accepted bit; a coincident rise on the same line keeps it set
   always_comb begin
      clr_s = 4'b0000;
      if (take_s) begin
         clr_s[enc_id_s] = 1'b1;
      end else begin
         clr_s = 4'b0000;
      end
      pending_d = (pending_q & ~clr_s) | rise_s;
   end

   // Edge detector, pending set and software-visible MASK/BASE registers
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q     <= 4'b0000;
         pending_q <= 4'b0000;
         mask_q    <= 4'b0000;
         base_q    <= RST_BASE;
      end else begin
         irq_q     <= irq;
         pending_q <= pending_d;
         if (regWe) begin
            case (regAddr)
               ADDR_MASK: mask_q <= regWd[NIRQ-1:0];
               ADDR_BASE: base_q <= {regWd[31:2], 2'b00};
               default:   ;
            endcase
         end
      end
   end

   // Control FSM with registered INT/busy/entryPoint and captured id/EPC
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         int_q   <= 1'b0;
         busy_q  <= 1'b0;
         id_q    <= 2'd0;
         epc_q   <= 32'h0000_0000;
         entry_q <= RST_BASE;
      end else begin
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               if (take_s) begin
                  state_q <= ASSERT;
                  int_q   <= 1'b1;
                  id_q    <= enc_id_s;
                  epc_q   <= pcNext;
                  entry_q <= base_q + vec_off_s;
               end else begin
                  int_q <= 1'b0;
               end
            end
            ASSERT: begin
               state_q <= SERVICE;
               int_q   <= 1'b0;
               busy_q  <= 1'b1;
            end
            SERVICE: begin
               int_q <= 1'b0;
               if (eoi_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  busy_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               int_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Register read mux
   always_comb begin
      regRd = 32'h0000_0000;
      case (regAddr)
         ADDR_MASK: regRd = {28'h000_0000, mask_q};
         ADDR_BASE: regRd = base_q;
         ADDR_EPC:  regRd = epc_q;
         ADDR_EOI:  regRd = {24'h00_0000, pending_q, id_q, state_q};
         default:   regRd = 32'h0000_0000;
      endcase
   end

   assign INT        = int_q;
   assign busy       = busy_q;
   assign entryPoint = entry_q;

endmodule

// File: tb/tb_y_int_ctrl.sv
// Directed self-checking bench for y_int_ctrl with hand-computed expectations.
module tb_y_int_ctrl;
   import y_int_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  irq;
   logic [31:0] pcNext;
   logic        regWe;
   logic [1:0]  regAddr;
   logic [31:0] regWd;
   logic [31:0] regRd;
   logic        INT;
   logic [31:0] entryPoint;
   logic        busy;

   int total  = 0;
   int passed = 0;
   int failed = 0;
   int pulses = 0;

   always #10 clk = ~clk;

   y_int_ctrl #(.VEC_SHIFT(4), .RST_BASE(32'h0000_0080)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq),
      .pcNext     (pcNext),
      .regWe      (regWe),
      .regAddr    (regAddr),
      .regWd      (regWd),
      .regRd      (regRd),
      .INT        (INT),
      .entryPoint (entryPoint),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rdchk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      regAddr = addr;
      #1;
      check(tag, regRd, exp);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      regWe   = 1'b1;
      regAddr = addr;
      regWd   = data;
      tick();
      regWe   = 1'b0;
      regWd   = 32'h0;
   endtask

   initial begin
      rst = 1'b1; irq = 4'b0000; pcNext = 32'h0; regWe = 1'b0; regAddr = 2'd0; regWd = 32'h0;
      tick(); tick();
      check("rst_int", {31'h0, INT}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_entry", entryPoint, 32'h0000_0080);
      rdchk("rst_mask", 2'd0, 32'h0);
      rdchk("rst_base", 2'd1, 32'h0000_0080);
      rdchk("rst_epc", 2'd2, 32'h0);
      rdchk("rst_status", 2'd3, 32'h0);
      rst = 1'b0;

      // basic vectoring, latency, EPC capture
      wr(2'd0, 32'hF);
      wr(2'd1, 32'h80);
      pcNext = 32'h1000; irq = 4'b0100;
      tick();
      check("t1_no_int_yet", {31'h0, INT}, 32'h0);
      tick();
      check("t1_int", {31'h0, INT}, 32'h1);
      check("t1_entry", entryPoint, 32'h0000_00A0);
      rdchk("t1_epc", 2'd2, 32'h1000);
      pcNext = 32'h2000;
      tick();
      check("t1_int_one_cycle", {31'h0, INT}, 32'h0);
      check("t1_busy", {31'h0, busy}, 32'h1);
      check("t1_entry_hold", entryPoint, 32'h0000_00A0);
      rdchk("t1_status", 2'd3, 32'h0A);
      // pulse irq[0] while servicing: must only pend
      irq = 4'b0101; tick();
      irq = 4'b0100; tick();
      rdchk("t1_pend_in_service", 2'd3, 32'h1A);
      wr(2'd3, 32'h0);
      check("t1_eoi_busy", {31'h0, busy}, 32'h0);
      rdchk("t1_eoi_idle", 2'd3, 32'h18);
      // rise on irq[0] in the same cycle its pending bit is taken
      irq = 4'b0101; pcNext = 32'h3000;
      tick();
      check("t1_rw_int", {31'h0, INT}, 32'h1);
      check("t1_rw_entry", entryPoint, 32'h0000_0080);
      rdchk("t1_rw_status", 2'd3, 32'h11);
      rdchk("t1_rw_epc", 2'd2, 32'h3000);
      tick();
      wr(2'd3, 32'h0);
      tick();
      check("t1_refire_int", {31'h0, INT}, 32'h1);
      rdchk("t1_refire_status", 2'd3, 32'h01);
      tick();
      wr(2'd3, 32'h0);
      irq = 4'b0000;
      tick();
      check("t1_quiet", {31'h0, INT}, 32'h0);

      // simultaneous rises, EOI gap, EOI in ASSERT ignored
      irq = 4'b1010; pcNext = 32'h4000;
      tick(); tick();
      check("t2_int", {31'h0, INT}, 32'h1);
      check("t2_entry", entryPoint, 32'h0000_0090);
      tick();
      rdchk("t2_status", 2'd3, 32'h86);
      wr(2'd3, 32'h0);
      check("t2_gap_int", {31'h0, INT}, 32'h0);
      rdchk("t2_gap_status", 2'd3, 32'h84);
      tick();
      check("t2_int2", {31'h0, INT}, 32'h1);
      check("t2_entry2", entryPoint, 32'h0000_00B0);
      wr(2'd3, 32'h0);
      rdchk("t2_eoi_in_assert", 2'd3, 32'h0E);
      wr(2'd3, 32'h0);
      irq = 4'b0000;
      tick();

      // masked pending fires once unmasked
      wr(2'd0, 32'h0);
      irq = 4'b0001;
      tick(); tick(); tick();
      check("t3_masked_int", {31'h0, INT}, 32'h0);
      rdchk("t3_masked_status", 2'd3, 32'h1C);
      wr(2'd0, 32'h1);
      check("t3_unmask_int0", {31'h0, INT}, 32'h0);
      tick();
      check("t3_unmask_int", {31'h0, INT}, 32'h1);
      check("t3_entry", entryPoint, 32'h0000_0080);
      tick();
      wr(2'd3, 32'h0);
      irq = 4'b0000;
      tick();

      // BASE low bits forced to zero, address wraps
      wr(2'd0, 32'hF);
      wr(2'd1, 32'hFFFF_FFF3);
      rdchk("t4_base", 2'd1, 32'hFFFF_FFF0);
      irq = 4'b1000;
      tick(); tick();
      check("t4_int", {31'h0, INT}, 32'h1);
      check("t4_entry_wrap", entryPoint, 32'h0000_0020);
      tick();
      wr(2'd3, 32'h0);
      irq = 4'b0000;
      tick();

      // reset mid-service with irq[1] pending
      irq = 4'b0010;
      tick(); tick(); tick();
      check("t5_busy", {31'h0, busy}, 32'h1);
      irq = 4'b0000; tick();
      irq = 4'b0010; tick();
      rdchk("t5_pending", 2'd3, 32'h26);
      rst = 1'b1; irq = 4'b0000;
      tick();
      check("t5_rst_int", {31'h0, INT}, 32'h0);
      check("t5_rst_busy", {31'h0, busy}, 32'h0);
      check("t5_rst_entry", entryPoint, 32'h0000_0080);
      rdchk("t5_rst_status", 2'd3, 32'h0);
      rdchk("t5_rst_base", 2'd1, 32'h0000_0080);
      rst = 1'b0;
      wr(2'd0, 32'hF);
      tick(); tick();
      check("t5_no_int_after_rst", {31'h0, INT}, 32'h0);
      rdchk("t5_status_after_rst", 2'd3, 32'h0);
      irq = 4'b0010; pcNext = 32'h5000;
      tick(); tick();
      check("t5_new_edge_int", {31'h0, INT}, 32'h1);
      check("t5_new_edge_entry", entryPoint, 32'h0000_0090);
      tick();
      wr(2'd3, 32'h0);
      irq = 4'b0000;
      tick();

      // EOI in IDLE ignored; level-held irq fires once
      wr(2'd3, 32'h0);
      rdchk("t6_idle_eoi", 2'd3, 32'h04);
      irq = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) begin
            regWe = 1'b1; regAddr = 2'd3;
         end
         tick();
         regWe = 1'b0;
         if (INT) pulses++;
      end
      check("t6_single_pulse", pulses, 32'd1);
      rdchk("t6_final_status", 2'd3, 32'h08);
      wr(2'd2, 32'hDEAD_BEEF);
      rdchk("t6_epc_ro", 2'd2, 32'h5000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
